// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC dot-product sequencer.
// Also holds the 4x4 vedic multiplier, built from 2x2 vedic blocks.
package mac_pkg;

  localparam int LEN_W_DEF = 4;
  localparam int ACC_W_DEF = 12;
  localparam int PROD_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [3:0] vedic2x2(input logic [1:0] a, input logic [1:0] b);
    logic t1, t2, t3, c1;
    t1 = a[1] & b[0];
    t2 = a[0] & b[1];
    t3 = a[1] & b[1];
    c1 = t1 & t2;
    return {t3 & c1, t3 ^ c1, t1 ^ t2, a[0] & b[0]};
  endfunction

  // Partial products are summed vertically and crosswise, then stitched above bit 1.
  function automatic logic [PROD_W-1:0] vedic4x4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] q0, q1, q2, q3;
    logic [5:0] s1;
    logic [5:0] s2;
    q0 = vedic2x2(a[1:0], b[1:0]);
    q1 = vedic2x2(a[3:2], b[1:0]);
    q2 = vedic2x2(a[1:0], b[3:2]);
    q3 = vedic2x2(a[3:2], b[3:2]);
    s1 = {4'b0000, q0[3:2]} + {2'b00, q1} + {2'b00, q2};
    s2 = s1 + {q3, 2'b00};
    return {s2, q0[1:0]};
  endfunction

endpackage

// File: rtl/mac_acc_unit.sv
// Multiply-accumulate datapath: vedic 4x4 product added into an ACC_W
// register with synchronous clear, enable and a sticky carry-out flag.
module mac_acc_unit
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [3:0]       i_a,
  input  logic [3:0]       i_b,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_ovf
);

  logic [PROD_W-1:0] w_prod;
  logic [ACC_W:0]    w_sum;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;

  assign w_prod = vedic4x4(i_a, i_b);
  assign w_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, w_prod};

  // Accumulator and sticky overflow; the top bit of w_sum is the carry out of ACC_W.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_ovf <= r_ovf | w_sum[ACC_W];
    end else begin
      r_acc <= r_acc;
      r_ovf <= r_ovf;
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/mac_dot_sequencer.sv
// Job controller for the MAC datapath: start/len command, operand
// valid/ready stream, and a held result on a valid/ready port.
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  input  logic             i_op_valid,
  input  logic [3:0]       i_op_a,
  input  logic [3:0]       i_op_b,
  output logic             o_op_ready,
  output logic             o_res_valid,
  output logic [ACC_W-1:0] o_res_data,
  output logic             o_res_ovf,
  input  logic             i_res_ready
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] r_len_q;
  logic             w_clr;
  logic             w_en;
  logic             w_beat;
  logic             w_last;
  logic             w_in_accum;
  logic             w_in_done;
  logic [ACC_W-1:0] w_acc;
  logic             w_ovf;

  assign w_in_accum = (r_state == ST_ACCUM);
  assign w_in_done  = (r_state == ST_DONE);
  assign w_beat     = i_op_valid & w_in_accum;
  assign w_last     = (r_count == (r_len_q - LEN_W'(1)));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_clr       = 1'b1;
          w_state_nxt = (i_len == LEN_W'(0)) ? ST_DONE : ST_ACCUM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (w_beat) begin
          w_en        = 1'b1;
          w_state_nxt = w_last ? ST_DONE : ST_ACCUM;
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (i_res_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Beat counter and job length, captured together with the accumulator clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_len_q <= '0;
    end else if (w_clr) begin
      r_count <= '0;
      r_len_q <= i_len;
    end else if (w_en) begin
      r_count <= r_count + LEN_W'(1);
    end else begin
      r_count <= r_count;
      r_len_q <= r_len_q;
    end
  end

  mac_acc_unit #(
    .ACC_W(ACC_W)
  ) u_acc (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(w_clr),
    .i_en (w_en),
    .i_a  (i_op_a),
    .i_b  (i_op_b),
    .o_acc(w_acc),
    .o_ovf(w_ovf)
  );

  // Result is masked outside DONE so the port reads zero while idle or accumulating.
  assign o_busy      = w_in_accum | w_in_done;
  assign o_op_ready  = w_in_accum;
  assign o_res_valid = w_in_done;
  assign o_res_data  = w_in_done ? w_acc : '0;
  assign o_res_ovf   = w_in_done & w_ovf;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboard bench for mac_dot_sequencer: a 12-bit and an 8-bit
// accumulator instance run the same jobs from shared stimulus.
module tb_mac_dot_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       op_valid;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       res_ready;

  logic        busy, op_ready, res_valid, res_ovf;
  logic [11:0] res_data;
  logic        busy8, op_ready8, res_valid8, res_ovf8;
  logic [7:0]  res_data8;

  typedef struct {
    logic [11:0] d12;
    logic        o12;
    logic [7:0]  d8;
    logic        o8;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] pa[16];
  logic [3:0] pb[16];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  mac_dot_sequencer #(.LEN_W(4), .ACC_W(12)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len), .o_busy(busy),
    .i_op_valid(op_valid), .i_op_a(op_a), .i_op_b(op_b), .o_op_ready(op_ready),
    .o_res_valid(res_valid), .o_res_data(res_data), .o_res_ovf(res_ovf),
    .i_res_ready(res_ready)
  );

  mac_dot_sequencer #(.LEN_W(4), .ACC_W(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len), .o_busy(busy8),
    .i_op_valid(op_valid), .i_op_a(op_a), .i_op_b(op_b), .o_op_ready(op_ready8),
    .o_res_valid(res_valid8), .o_res_data(res_data8), .o_res_ovf(res_ovf8),
    .i_res_ready(res_ready)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference sums computed with plain integer arithmetic.
  function automatic exp_t model(input int n);
    exp_t e;
    int   s12;
    int   s8;
    e.o12 = 1'b0;
    e.o8  = 1'b0;
    s12   = 0;
    s8    = 0;
    for (int i = 0; i < n; i++) begin
      s12 += int'(pa[i]) * int'(pb[i]);
      s8  += int'(pa[i]) * int'(pb[i]);
      if (s12 >= 4096) begin e.o12 = 1'b1; s12 -= 4096; end
      if (s8 >= 256)   begin e.o8  = 1'b1; s8  -= 256;  end
    end
    e.d12 = s12[11:0];
    e.d8  = s8[7:0];
    return e;
  endfunction

  task automatic start_job(input int n);
    sb_q.push_back(model(n));
    start = 1'b1;
    len   = 4'(n);
    step();
    start = 1'b0;
  endtask

  task automatic feed(input int idx, input int gap);
    int t;
    op_valid = 1'b0;
    repeat (gap) step();
    op_a     = pa[idx];
    op_b     = pb[idx];
    op_valid = 1'b1;
    t = 0;
    while (!op_ready && t < 20) begin
      step();
      t++;
    end
    if (!op_ready) check_val("op_ready_timeout", 32'(op_ready), 32'd1);
    step();
    op_valid = 1'b0;
    op_a     = 4'hx;
    op_b     = 4'hx;
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   t;
    t = 0;
    while (!res_valid && t < 40) begin
      step();
      t++;
    end
    check_val("res_valid_seen", 32'(res_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q[0];
    res_ready = 1'b0;
    start     = 1'b1;
    len       = 4'd3;
    for (int k = 0; k < hold; k++) begin
      check_val("hold_valid", 32'(res_valid), 32'd1);
      check_val("hold_data", 32'(res_data), 32'(e.d12));
      check_val("hold_op_ready", 32'(op_ready), 32'd0);
      step();
    end
    check_val("res_data", 32'(res_data), 32'(e.d12));
    check_val("res_ovf", 32'(res_ovf), 32'(e.o12));
    check_val("res8_valid", 32'(res_valid8), 32'd1);
    check_val("res8_data", 32'(res_data8), 32'(e.d8));
    check_val("res8_ovf", 32'(res_ovf8), 32'(e.o8));
    void'(sb_q.pop_front());
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    start     = 1'b0;
    check_val("post_valid", 32'(res_valid), 32'd0);
    check_val("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_job(input int n, input bit gapped, input int hold);
    start_job(n);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) check_val("pre_last_valid", 32'(res_valid), 32'd0);
      feed(i, gapped ? 1 + (i % 3) : 0);
    end
    check_val("latency_valid", 32'(res_valid), 32'd1);
    collect(hold);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_op_ready"}, 32'(op_ready), 32'd0);
    check_val({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check_val({tag, "_res_data"}, 32'(res_data), 32'd0);
    check_val({tag, "_res_ovf"}, 32'(res_ovf), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 4'd0; op_valid = 1'b0;
    op_a = 4'd0; op_b = 4'd0; res_ready = 1'b0;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();

    pa[0] = 4'd3;  pb[0] = 4'd5;
    pa[1] = 4'd15; pb[1] = 4'd15;
    pa[2] = 4'd0;  pb[2] = 4'd9;
    pa[3] = 4'd2;  pb[3] = 4'd7;
    run_job(4, 1'b0, 0);
    run_job(4, 1'b1, 5);

    start = 1'b1;
    len   = 4'd0;
    sb_q.push_back(model(0));
    step();
    start = 1'b0;
    check_val("len0_valid", 32'(res_valid), 32'd1);
    check_val("len0_op_ready", 32'(op_ready), 32'd0);
    check_val("len0_data", 32'(res_data), 32'd0);
    collect(1);

    pa[0] = 4'd15; pb[0] = 4'd15;
    pa[1] = 4'd15; pb[1] = 4'd15;
    run_job(2, 1'b0, 0);

    pa[0] = 4'd9;  pb[0] = 4'd11;
    pa[1] = 4'd13; pb[1] = 4'd6;
    pa[2] = 4'd7;  pb[2] = 4'd8;
    pa[3] = 4'd1;  pb[3] = 4'd1;
    start_job(4);
    feed(0, 0);
    feed(1, 1);
    rst = 1'b1;
    step();
    check_zero("midrst");
    check_val("midrst8_valid", 32'(res_valid8), 32'd0);
    void'(sb_q.pop_back());
    rst = 1'b0;
    step();

    pa[0] = 4'd4; pb[0] = 4'd4;
    run_job(1, 1'b0, 2);

    for (int i = 0; i < 15; i++) begin
      pa[i] = 4'($urandom_range(0, 15));
      pb[i] = 4'($urandom_range(0, 15));
    end
    run_job(15, 1'b1, 1);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
